// File: rtl/ext_trigger_responder_if.sv
// Purpose : trigger handshake bundle between a trigger generator and the detector-side responder.
// Latency : n/a (wires only).
// Backpress: trig_out high tells the generator not to fire again until it drops.
// Signals : trig_in (active-low trigger, idle high), err_clr (clears sticky flags),
//           trig_out (busy), trig_valid (accept pulse), trig_count, err_runt, err_overlap.
interface ext_trigger_responder_if #(
    parameter int CNT_W = 16
);
    logic             trig_in;
    logic             err_clr;
    logic             trig_out;
    logic             trig_valid;
    logic [CNT_W-1:0] trig_count;
    logic             err_runt;
    logic             err_overlap;

    // Generator / board side: drives the trigger, watches busy and status.
    modport master (
        output trig_in,
        output err_clr,
        input  trig_out,
        input  trig_valid,
        input  trig_count,
        input  err_runt,
        input  err_overlap
    );

    // Responder side.
    modport slave (
        input  trig_in,
        input  err_clr,
        output trig_out,
        output trig_valid,
        output trig_count,
        output err_runt,
        output err_overlap
    );
endinterface

// File: rtl/ext_trigger_responder.sv
// Purpose : detector stand-in; qualifies the active-low trigger width, answers with a fixed busy window.
// Latency : busy rises 2 + MIN_TICKS cycles after trig_in falls (2-flop sync + width qualification).
// Backpress: trig_out high for BUSY_TICKS cycles; edges during busy are flagged and ignored.
// Ports   : i_clk, i_rst_n (async active-low), trig_bus (slave modport: trig_in/err_clr in,
//           trig_out/trig_valid/trig_count/err_runt/err_overlap out, all outputs registered).
module ext_trigger_responder #(
    parameter int CLK_MHZ        = 24,
    parameter int T_US_MIN_PULSE = 10,
    parameter int T_US_BUSY      = 1000,
    parameter int CNT_W          = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    ext_trigger_responder_if.slave  trig_bus
);

    localparam int MIN_TICKS  = T_US_MIN_PULSE * CLK_MHZ;
    localparam int BUSY_TICKS = T_US_BUSY * CLK_MHZ;
    localparam int MIN_W      = $clog2(MIN_TICKS + 1);
    localparam int BUSY_W     = $clog2(BUSY_TICKS + 1);

    // Width counter value at which the current low sample is the MIN_TICKS-th one.
    localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(MIN_TICKS - 1);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_TICKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_BUSY,
        S_WAIT_HIGH
    } state_t;

    state_t            r_state;
    logic              r_sync1;
    logic              r_trig_s;
    logic              r_trig_prev;
    logic [MIN_W-1:0]  r_width;
    logic [BUSY_W-1:0] r_busy_cnt;
    logic              r_trig_out;
    logic              r_trig_valid;
    logic [CNT_W-1:0]  r_trig_count;
    logic              r_err_runt;
    logic              r_err_overlap;

    logic              w_fall;
    logic              w_accept;

    assign w_fall = r_trig_prev & ~r_trig_s;

    // The IDLE sample that starts measurement is the first low sample, so with
    // MIN_TICKS == 1 that sample alone accepts and a runt cannot happen.
    always_comb begin
        w_accept = 1'b0;
        if (!r_trig_s) begin
            if (r_state == S_IDLE && MIN_TICKS == 1)
                w_accept = 1'b1;
            else if (r_state == S_MEASURE && r_width == MIN_LAST)
                w_accept = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_sync1       <= 1'b1;
            r_trig_s      <= 1'b1;
            r_trig_prev   <= 1'b1;
            r_width       <= '0;
            r_busy_cnt    <= '0;
            r_trig_out    <= 1'b0;
            r_trig_valid  <= 1'b0;
            r_trig_count  <= '0;
            r_err_runt    <= 1'b0;
            r_err_overlap <= 1'b0;
        end else begin
            r_sync1      <= trig_bus.trig_in;
            r_trig_s     <= r_sync1;
            r_trig_prev  <= r_trig_s;
            r_trig_valid <= 1'b0;

            // Clear first; any set below in the same cycle overrides it.
            if (trig_bus.err_clr) begin
                r_err_runt    <= 1'b0;
                r_err_overlap <= 1'b0;
            end

            if (w_accept) begin
                r_state      <= S_BUSY;
                r_busy_cnt   <= BUSY_W'(1);
                r_trig_out   <= 1'b1;
                r_trig_valid <= 1'b1;
                r_trig_count <= r_trig_count + 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_trig_out <= 1'b0;
                        // Level-sensitive so a line already low at reset release is still measured.
                        if (!r_trig_s) begin
                            r_state <= S_MEASURE;
                            r_width <= MIN_W'(1);
                        end
                    end
                    S_MEASURE: begin
                        if (r_trig_s) begin
                            r_err_runt <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_width <= r_width + 1'b1;
                        end
                    end
                    S_BUSY: begin
                        if (w_fall)
                            r_err_overlap <= 1'b1;
                        if (r_busy_cnt == BUSY_LAST) begin
                            r_trig_out <= 1'b0;
                            r_state    <= r_trig_s ? S_IDLE : S_WAIT_HIGH;
                        end else begin
                            r_busy_cnt <= r_busy_cnt + 1'b1;
                        end
                    end
                    S_WAIT_HIGH: begin
                        // A held-low line must return high before it can trigger again.
                        if (r_trig_s)
                            r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign trig_bus.trig_out    = r_trig_out;
    assign trig_bus.trig_valid  = r_trig_valid;
    assign trig_bus.trig_count  = r_trig_count;
    assign trig_bus.err_runt    = r_err_runt;
    assign trig_bus.err_overlap = r_err_overlap;

endmodule

// File: tb/tb_ext_trigger_responder.sv
// Purpose : self-checking bench for ext_trigger_responder with a scoreboard of expected accepts.
// Latency : expects busy rise 6 cycles after trig_in falls (CLK_MHZ=1, 4 us min, 20 us busy).
// Backpress: new triggers are only issued after trig_out has dropped, except deliberate overlaps.
module tb_ext_trigger_responder;

    localparam int CLK_MHZ        = 1;
    localparam int T_US_MIN_PULSE = 4;
    localparam int T_US_BUSY      = 20;
    localparam int CNT_W          = 4;
    localparam int MIN_TICKS      = T_US_MIN_PULSE * CLK_MHZ;
    localparam int BUSY_TICKS     = T_US_BUSY * CLK_MHZ;
    localparam int RISE_DLY       = 2 + MIN_TICKS;

    logic clk;
    logic rst_n;

    ext_trigger_responder_if #(.CNT_W(CNT_W)) bus ();

    ext_trigger_responder #(
        .CLK_MHZ        (CLK_MHZ),
        .T_US_MIN_PULSE (T_US_MIN_PULSE),
        .T_US_BUSY      (T_US_BUSY),
        .CNT_W          (CNT_W)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .trig_bus (bus.slave)
    );

    typedef struct {
        int cnt;
        int cyc;
    } exp_t;

    exp_t q_exp[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   exp_cnt = 0;
    int   hi_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    endtask

    // Caller aligns to #1 after a posedge; trig_in is low for exactly len samples.
    task automatic pulse(input int len, input bit accept);
        exp_t e;
        if (accept) begin
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            e.cnt = exp_cnt;
            e.cyc = cyc + RISE_DLY;
            q_exp.push_back(e);
        end
        bus.trig_in = 1'b0;
        repeat (len) @(posedge clk);
        #1 bus.trig_in = 1'b1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.trig_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_idle_timeout", 1, 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accept pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && bus.trig_valid) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("valid_count", int'(bus.trig_count), e.cnt);
                chk("out_rise", int'(bus.trig_out), 1);
            end
        end
    end

    // Busy window width, ignored when cut short by reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            hi_cnt = 0;
        end else if (bus.trig_out) begin
            hi_cnt++;
        end else if (hi_cnt != 0) begin
            chk("busy_width", hi_cnt, BUSY_TICKS);
            hi_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s;
        rst_n       = 1'b0;
        bus.trig_in = 1'b1;
        bus.err_clr = 1'b0;
        #15;
        chk("rst_out",     int'(bus.trig_out), 0);
        chk("rst_valid",   int'(bus.trig_valid), 0);
        chk("rst_count",   int'(bus.trig_count), 0);
        chk("rst_runt",    int'(bus.err_runt), 0);
        chk("rst_overlap", int'(bus.err_overlap), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 1. clean trigger
        pulse(8, 1'b1);
        wait_idle();
        chk("t1_count",   int'(bus.trig_count), 1);
        chk("t1_runt",    int'(bus.err_runt), 0);
        chk("t1_overlap", int'(bus.err_overlap), 0);

        // 2. runt
        pulse(2, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("t2_runt",  int'(bus.err_runt), 1);
        chk("t2_count", int'(bus.trig_count), exp_cnt);
        chk("t2_out",   int'(bus.trig_out), 0);
        @(posedge clk); #1 bus.err_clr = 1'b1;
        @(posedge clk); #1 bus.err_clr = 1'b0;
        @(negedge clk);
        chk("t2_runt_clr", int'(bus.err_runt), 0);
        @(posedge clk); #1;

        // 3. overlap at busy cycle 10
        pulse(8, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        pulse(5, 1'b0);
        @(negedge clk);
        chk("t3_overlap", int'(bus.err_overlap), 1);
        wait_idle();
        chk("t3_count", int'(bus.trig_count), exp_cnt);
        chk("t3_runt",  int'(bus.err_runt), 0);
        @(posedge clk); #1 bus.err_clr = 1'b1;
        @(posedge clk); #1 bus.err_clr = 1'b0;
        @(negedge clk);
        chk("t3_overlap_clr", int'(bus.err_overlap), 0);
        @(posedge clk); #1;

        // 4. stuck low for 60 cycles
        s = exp_cnt;
        begin
            exp_t e;
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            e.cnt = exp_cnt;
            e.cyc = cyc + RISE_DLY;
            q_exp.push_back(e);
        end
        bus.trig_in = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("t4_out_low_held", int'(bus.trig_out), 0);
        chk("t4_count_held",   int'(bus.trig_count), (s + 1) % (1 << CNT_W));
        repeat (20) @(posedge clk);
        #1 bus.trig_in = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        pulse(8, 1'b1);
        wait_idle();
        chk("t4_count", int'(bus.trig_count), (s + 2) % (1 << CNT_W));

        // 5. wrap: 17 triggers back to back
        s = exp_cnt;
        for (int i = 0; i < 17; i++) begin
            pulse(8, 1'b1);
            wait_idle();
        end
        chk("t5_count", int'(bus.trig_count), (s + 17) % (1 << CNT_W));

        // 6. async reset at busy cycle 7, with a runt flag already set
        pulse(2, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("t6_runt_pre", int'(bus.err_runt), 1);
        @(posedge clk); #1;
        pulse(8, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_out_pre", int'(bus.trig_out), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_out",     int'(bus.trig_out), 0);
        chk("t6_count",   int'(bus.trig_count), 0);
        chk("t6_runt",    int'(bus.err_runt), 0);
        chk("t6_overlap", int'(bus.err_overlap), 0);
        exp_cnt = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pulse(8, 1'b1);
        wait_idle();
        chk("t6_count_after", int'(bus.trig_count), 1);

        repeat (5) @(posedge clk);
        chk("queue_empty", q_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ext_trigger_responder.md
Name: ext_trigger_responder

Overview:
- Detector-side end of the external trigger handshake.
- Receives the active-low trigger pulse on `trig_in` (pull-up line) and qualifies its width.
- Answers by driving `trig_out` high (busy) for a fixed readout time. The trigger generator may only fire again once `trig_out` is low.
- Used as a detector stand-in on the board and as the bench partner for the trigger generator. Also reports trigger count and protocol errors.

Parameters:
- CLK_MHZ, 24, system clock cycles per microsecond
- T_US_MIN_PULSE, 10, minimum accepted `trig_in` low width in microseconds; MIN_TICKS = T_US_MIN_PULSE*CLK_MHZ (must be >= 1)
- T_US_BUSY, 1000, `trig_out` busy width in microseconds; BUSY_TICKS = T_US_BUSY*CLK_MHZ (must be >= 1)
- CNT_W, 16, width of the trigger counter

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- trig_in  input  1  asynchronous trigger from generator, active low, idle high
- err_clr  input  1  synchronous, clears the sticky error flags
- trig_out  output  1  busy to generator; high = not ready
- trig_valid  output  1  one-cycle pulse per accepted trigger
- trig_count  output  CNT_W  accepted trigger count
- err_runt  output  1  sticky: a low pulse shorter than MIN_TICKS was seen
- err_overlap  output  1  sticky: a falling edge arrived while busy

Behaviour:
- Reset (async, rst_n=0):
  - trig_out=0, trig_valid=0, trig_count=0, err_runt=0, err_overlap=0.
  - Synchronizer flops = 1; state = IDLE; counters = 0.
- Input sync:
  - `trig_in` passes through a 2-flop synchronizer (`trig_s`), giving 2 cycles of latency.
  - A falling edge is `trig_s`=0 with a registered previous value of 1.
- Counter widths: $clog2(MIN_TICKS+1) and $clog2(BUSY_TICKS+1).
- IDLE:
  - trig_out=0.
  - If `trig_s`=0 -> MEASURE with the width counter set to 1.
- MEASURE:
  - If `trig_s`=1 before the width counter reaches MIN_TICKS: set err_runt, go to IDLE. No count change, no `trig_valid`.
  - When the width counter reaches MIN_TICKS with `trig_s` still 0: go to BUSY.
  - In that same cycle, register trig_out<=1, trig_valid<=1 (one cycle) and trig_count<=trig_count+1 (wraps modulo 2^CNT_W).
  - Resulting first visible `trig_out` high is on cycle (2 + MIN_TICKS) after `trig_in` falls.
- BUSY:
  - `trig_out` is high for exactly BUSY_TICKS cycles.
  - On the last cycle, register trig_out<=0. Next state is WAIT_HIGH if `trig_s`=0, else IDLE.
- WAIT_HIGH:
  - Holds until `trig_s`=1, then goes to IDLE.
  - A line held low never retriggers.
- Overlap: a falling edge on `trig_s` while in BUSY sets err_overlap.
  - The edge is ignored: the busy timer is not restarted and the count does not change.
- Sticky flags:
  - err_runt and err_overlap stay set until err_clr=1 or reset.
  - If a set event and err_clr occur in the same cycle, set wins.
- MIN_TICKS=1 case: one low sample is enough to accept, so a runt cannot occur.
- Reset mid-BUSY: trig_out drops immediately (async). After release, the block resumes in IDLE and needs a fresh low level.
- Mid-pulse reset release: if `trig_in` is low when rst_n releases, `trig_s` is sampled low after 2 cycles with no falling edge. IDLE then enters MEASURE anyway, because IDLE is level-sensitive.

Test Plan:
Bench uses CLK_MHZ=1, T_US_MIN_PULSE=4, T_US_BUSY=20, CNT_W=4.
1. Clean trigger: drive `trig_in` low for 8 cycles starting at cycle 0 -> `trig_valid` pulse and `trig_out` rise at cycle 6; `trig_out` high for exactly 20 cycles; trig_count=1; no error flags.
2. Runt: `trig_in` low for 2 cycles -> err_runt=1, trig_count unchanged, `trig_out` stays 0. Then err_clr for one cycle -> err_runt=0.
3. Overlap: accept a trigger, then pulse `trig_in` low for 5 cycles at busy cycle 10 -> err_overlap=1; `trig_out` still falls 20 cycles after its rise; trig_count=1.
4. Stuck low: hold `trig_in` low for 60 cycles -> exactly one accepted trigger. `trig_out` is high for 20 cycles, then stays 0 (WAIT_HIGH). After release plus a new valid pulse, trig_count=2.
5. Wrap: 17 valid triggers back to back (each starting after `trig_out` falls) -> trig_count=1.
6. Async reset asserted at busy cycle 7 -> `trig_out`, trig_count and flags are 0 in the same cycle. After release, a valid pulse is accepted normally with trig_count=1.
